// File: rtl/mult4_share_sched.sv
// Round-robin scheduler that time-shares one unsigned W x W array multiplier
// among N_REQ requesters and returns each product with its requester ID.

module mult4_array #(
  parameter int W = 4
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] o
);

  // Shift-and-add array: one partial-product row per bit of y.
  always_comb begin
    o = {(2*W){1'b0}};
    for (int i = 0; i < W; i++) begin
      o = o + (y[i] ? ({{W{1'b0}}, x} << i) : {(2*W){1'b0}});
    end
  end

endmodule

module mult4_share_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*W-1:0]     resp_o,
  output logic [ID_W-1:0]    resp_id,
  output logic               busy,
  output logic [CNT_W-1:0]   ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   op_id;
  logic [W-1:0]      op_x;
  logic [W-1:0]      op_y;
  logic [2*W-1:0]    mult_o;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W:0]     cand;
  logic              any_valid;
  logic              take;

  mult4_array #(.W(W)) u_mult (
    .x (op_x),
    .y (op_y),
    .o (mult_o)
  );

  // Round-robin search: scanning from the far end down means the last hit
  // is the first valid requester at or after the pointer.
  always_comb begin
    gnt_idx   = {ID_W{1'b0}};
    any_valid = 1'b0;
    cand      = {(ID_W+1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end else begin
        cand = cand;
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_idx   = cand[ID_W-1:0];
        any_valid = 1'b1;
      end else begin
        gnt_idx   = gnt_idx;
        any_valid = any_valid;
      end
    end
  end

  assign take     = !rst && any_valid && ((state == IDLE) || ((state == HOLD) && resp_ready));
  assign next_ptr = (gnt_idx == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : gnt_idx + ID_W'(1);

  // One-hot accept toward the granted requester.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if (take) begin
      req_ready[gnt_idx] = 1'b1;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // Scheduler FSM with registered response, busy flag and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= {ID_W{1'b0}};
      op_x       <= {W{1'b0}};
      op_y       <= {W{1'b0}};
      op_id      <= {ID_W{1'b0}};
      resp_valid <= 1'b0;
      resp_o     <= {(2*W){1'b0}};
      resp_id    <= {ID_W{1'b0}};
      busy       <= 1'b0;
      ops_done   <= {CNT_W{1'b0}};
    end else begin
      if (take) begin
        op_x  <= req_x[gnt_idx*W +: W];
        op_y  <= req_y[gnt_idx*W +: W];
        op_id <= gnt_idx;
        ptr   <= next_ptr;
      end
      case (state)
        IDLE: begin
          if (take) begin
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          resp_o     <= mult_o;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (resp_ready) begin
            ops_done   <= ops_done + CNT_W'(1);
            resp_valid <= 1'b0;
            if (take) begin
              state <= CALC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_share_sched.sv
// Self-checking bench: directed table and corner sequences plus random traffic
// checked every cycle against a behavioural model of the scheduler.

module tb_mult4_share_sched;

  localparam int N = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [4*N-1:0] req_x;
  logic [4*N-1:0] req_y;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [7:0]    resp_o;
  logic [1:0]    resp_id;
  logic          busy;
  logic [CW-1:0] ops_done;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  int m_ptr, m_calc, m_cp, m_cid, m_rv, m_ro, m_rid, m_cnt, m_gnt;

  typedef struct {
    int id;
    int x;
    int y;
    int exp_o;
  } vec_t;
  vec_t tbl[6];

  mult4_share_sched #(.N_REQ(N), .W(4), .ID_W(2), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_o     (resp_o),
    .resp_id    (resp_id),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_calc = 0; m_cp = 0; m_cid = 0;
    m_rv = 0; m_ro = 0; m_rid = 0; m_cnt = 0; m_gnt = -1;
  endtask

  task automatic set_op(input int id, input int x, input int y);
    req_x[id*4 +: 4] = 4'(x);
    req_y[id*4 +: 4] = 4'(y);
  endtask

  // Called at posedge+1 with inputs driven; checks, then advances one clock.
  task automatic cycle();
    int g, x, y;
    #2;
    g = (!rst && !m_calc && (!m_rv || resp_ready)) ? pick(req_valid, m_ptr) : -1;
    chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    chk("resp_valid", int'(resp_valid), m_rv);
    chk("resp_o", int'(resp_o), m_ro);
    chk("resp_id", int'(resp_id), m_rid);
    chk("busy", int'(busy), (m_calc || m_rv) ? 1 : 0);
    chk("ops_done", int'(ops_done), m_cnt);
    if (rst) begin
      m_reset();
    end else begin
      if (m_rv && resp_ready) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_rv  = 0;
      end
      if (m_calc) begin
        m_rv = 1; m_ro = m_cp; m_rid = m_cid; m_calc = 0;
      end
      m_gnt = g;
      if (g >= 0) begin
        x = int'(req_x[g*4 +: 4]);
        y = int'(req_y[g*4 +: 4]);
        m_calc = 1; m_cp = x * y; m_cid = g; m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_one(input int id, input int x, input int y, input int exp_o);
    int n;
    req_valid = '0; req_valid[id] = 1'b1;
    set_op(id, x, y);
    resp_ready = 1'b1;
    n = 0;
    while (req_valid[id] && n < 20) begin
      cycle();
      if (m_gnt == id) req_valid[id] = 1'b0;
      n++;
    end
    n = 0;
    while (!resp_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("run_one_resp_valid", int'(resp_valid), 1);
    chk("run_one_o", int'(resp_o), exp_o);
    chk("run_one_id", int'(resp_id), id);
    cycle();
  endtask

  initial begin
    int q_o[$];
    int q_id[$];
    int q_c[$];
    int exp_o5[5] = '{15, 30, 45, 60, 15};
    int exp_id5[5] = '{0, 1, 2, 3, 0};

    tbl[0] = '{id: 0, x: 3,  y: 5,  exp_o: 15};
    tbl[1] = '{id: 1, x: 15, y: 15, exp_o: 225};
    tbl[2] = '{id: 2, x: 0,  y: 9,  exp_o: 0};
    tbl[3] = '{id: 3, x: 7,  y: 8,  exp_o: 56};
    tbl[4] = '{id: 2, x: 15, y: 1,  exp_o: 15};
    tbl[5] = '{id: 1, x: 12, y: 11, exp_o: 132};

    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    do_reset();
    chk("reset_resp_valid", int'(resp_valid), 0);
    chk("reset_ops_done", int'(ops_done), 0);

    // First transaction, step by step.
    req_valid = 4'b0001; set_op(0, 3, 5); resp_ready = 1'b1;
    #1;
    chk("first_req_ready", int'(req_ready), 1);
    cycle();
    req_valid = '0;
    cycle();
    chk("first_resp_valid", int'(resp_valid), 1);
    chk("first_resp_o", int'(resp_o), 15);
    chk("first_resp_id", int'(resp_id), 0);
    cycle();
    chk("first_ops_done", int'(ops_done), 1);

    // Table of single operations.
    for (int i = 0; i < 6; i++) begin
      run_one(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].exp_o);
    end

    // All requesters continuously valid: round-robin and 2-cycle cadence.
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 15);
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (resp_valid) begin
        q_o.push_back(int'(resp_o)); q_id.push_back(int'(resp_id)); q_c.push_back(c);
      end
    end
    chk("rr_count", (q_o.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5 && i < q_o.size(); i++) begin
      chk("rr_o", q_o[i], exp_o5[i]);
      chk("rr_id", q_id[i], exp_id5[i]);
      if (i > 0) chk("rr_gap", q_c[i] - q_c[i-1], 2);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) cycle();

    // Backpressure: response held while requester 2 waits.
    do_reset();
    resp_ready = 1'b0;
    req_valid = 4'b0010; set_op(1, 9, 9);
    cycle();
    req_valid = '0;
    cycle();
    req_valid = 4'b0100; set_op(2, 5, 6);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_req_ready", int'(req_ready), 0);
      cycle();
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_o", int'(resp_o), 81);
      chk("hold_id", int'(resp_id), 1);
    end
    resp_ready = 1'b1;
    #1;
    chk("hold_release_ready", int'(req_ready), 4);
    cycle();
    req_valid = '0;
    chk("b2b_busy", int'(busy), 1);
    cycle();
    chk("b2b_valid", int'(resp_valid), 1);
    chk("b2b_o", int'(resp_o), 30);
    chk("b2b_id", int'(resp_id), 2);
    cycle();

    // Reset during CALC with two requests pending.
    do_reset();
    run_one(0, 2, 2, 4);
    req_valid = 4'b1010; set_op(1, 4, 4); set_op(2, 3, 3); set_op(3, 1, 1);
    cycle();
    chk("midrst_grant", m_gnt, 1);
    req_valid = 4'b1100;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_valid", int'(resp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ops", int'(ops_done), 0);
    #1;
    chk("midrst_next_grant", int'(req_ready), 4);
    cycle();
    req_valid = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
    end

    // Counter wrap on the narrow build.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) run_one(i % N, i % 16, 3, (i % 16) * 3);
    chk("wrap_full", int'(ops_done), (1 << CW) - 1);
    run_one(0, 1, 1, 1);
    chk("wrap_zero", int'(ops_done), 0);

    // Random traffic obeying the hold-until-accepted rule.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
      end
      cycle();
      if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
